// File: rtl/ro_puf_pkg.sv
// Shared defaults, FSM state encoding and debug view for the RO PUF sequencer.
package ro_puf_pkg;

    localparam int NUM_RO_DEF  = 9;
    localparam int COUNT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    // Observability bundle: current state, oscillator index and latched challenge.
    typedef struct packed {
        state_t     state;
        logic [3:0] idx;
        logic [7:0] challenge;
    } dbg_t;

endpackage

// File: rtl/ro_window_timer.sv
// Enable-window timer: cleared by load, counts while run, pulses done on its last cycle.
module ro_window_timer #(
    parameter int WINDOW = 'h100000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic done
);

    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

    logic [TW-1:0] timer;

    // Equality compare only: the count returns to zero instead of wrapping.
    assign done = run && (timer == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (load || done) begin
            timer <= '0;
        end else if (run) begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/ro_puf_sequencer.sv
// Steps through NUM_RO ring oscillators, captures each edge count and emits the
// neighbour-comparison response bits.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO     = NUM_RO_DEF,
    parameter int COUNT_W    = COUNT_W_DEF,
    parameter int WINDOW     = 'h100000,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          challenge,
    output logic [5:0]          ro_challenge,
    output logic [3:0]          ro_sel,
    output logic                ro_en,
    output logic                cnt_clear,
    input  logic [COUNT_W-1:0]  cnt_value,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [NUM_RO-2:0]   response,
    output logic                sat,
    output logic                busy,
    output dbg_t                dbg
);

    // Handshakes: a transfer happens on a clk edge where valid && ready are both
    // high; valid never waits on ready, and the payload holds while valid is up.

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [3:0]    IDX_LAST    = 4'(NUM_RO - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          idx;
    logic [7:0]          challenge_q;
    logic                sat_q;
    logic [NUM_RO-2:0]   response_q;
    logic [SW-1:0]       settle_cnt;
    logic [COUNT_W-1:0]  count [NUM_RO];
    logic                timer_load;
    logic                timer_run;
    logic                timer_done;

    ro_window_timer #(
        .WINDOW (WINDOW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .run   (timer_run),
        .done  (timer_done)
    );

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_run  = 1'b0;
        case (state)
            IDLE:    if (req_valid) state_nxt = CLEAR;
            CLEAR: begin
                timer_load = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                timer_run = 1'b1;
                if (timer_done) state_nxt = SETTLE;
            end
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (idx == IDX_LAST) ? COMPARE : CLEAR;
            COMPARE: state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            challenge_q <= '0;
            sat_q       <= 1'b0;
            response_q  <= '0;
            settle_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        challenge_q <= challenge;
                        idx         <= '0;
                        sat_q       <= 1'b0;
                    end
                end
                RUN:    settle_cnt <= '0;
                SETTLE: settle_cnt <= settle_cnt + SW'(1);
                CAPTURE: begin
                    sat_q <= sat_q | (&cnt_value);
                    if (idx != IDX_LAST) idx <= idx + 4'd1;
                end
                COMPARE: begin
                    for (int i = 0; i < NUM_RO - 1; i++) begin
                        response_q[i] <= (count[i] > count[i+1]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Count storage carries no reset: every slot is rewritten before COMPARE reads it.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            count[idx] <= cnt_value;
        end
    end

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign cnt_clear    = (state == CLEAR);
    assign ro_en        = (state == RUN);
    assign resp_valid   = (state == DONE);
    assign ro_sel       = idx;
    assign ro_challenge = challenge_q[5:0];
    assign response     = response_q;
    assign sat          = sat_q;

    assign dbg.state     = state;
    assign dbg.idx       = idx;
    assign dbg.challenge = challenge_q;

endmodule

// File: doc/ro_puf_sequencer.md
RO_PUF_SEQUENCER -- requirements
Module: ro_puf_sequencer

Interface
REQ-001 SHALL have parameter NUM_RO, default 9, number of ring oscillators sequenced (2..16).
REQ-002 SHALL have parameter COUNT_W, default 32, width of each edge count.
REQ-003 SHALL have parameter WINDOW, default 'h100000, RO enable window length in CLK cycles (>=2).
REQ-004 SHALL have parameter SETTLE_CYC, default 2, cycles waited after disable for the synchronized count to stabilise (>=1).
REQ-005 SHALL have ports: CLK in 1, sole clock; RESET in 1, synchronous active-high reset.
REQ-006 SHALL have ports: REQ_VALID in 1, REQ_READY out 1, CHALLENGE in 8; request handshake.
REQ-007 SHALL have ports: RO_CHALLENGE out 6, RO_SEL out 4, RO_EN out 1, CNT_CLEAR out 1; oscillator and counter control.
REQ-008 SHALL have port CNT_VALUE in COUNT_W, edge count already synchronized to CLK.
REQ-009 SHALL have ports: RESP_VALID out 1, RESP_READY in 1, RESPONSE out NUM_RO-1, SAT out 1, BUSY out 1.

Function
REQ-010 SHALL implement states IDLE, CLEAR, RUN, SETTLE, CAPTURE, COMPARE, DONE.
REQ-011 IDLE: REQ_READY=1; on REQ_VALID&&REQ_READY latch CHALLENGE, idx=0, clear SAT, go CLEAR.
REQ-012 REQ_READY SHALL be 0 in every state except IDLE; requests while busy are not accepted.
REQ-013 RO_CHALLENGE SHALL equal latched CHALLENGE[5:0], stable from accept until next accept.
REQ-014 CLEAR: CNT_CLEAR=1, RO_EN=0 for exactly one cycle, then RUN.
REQ-015 RUN: RO_EN=1 for exactly WINDOW cycles (timer 0..WINDOW-1), then SETTLE.
REQ-016 SETTLE: RO_EN=0 for exactly SETTLE_CYC cycles, then CAPTURE.
REQ-017 CAPTURE (1 cycle): count[idx]<=CNT_VALUE; SAT|=(CNT_VALUE=={COUNT_W{1}}); if idx==NUM_RO-1 go COMPARE else idx+=1, go CLEAR.
REQ-018 RO_SEL SHALL equal idx in all non-IDLE states; RO_EN SHALL never be 1 outside RUN.
REQ-019 COMPARE (1 cycle): RESPONSE[i]<=(count[i]>count[i+1]) unsigned, i=0..NUM_RO-2; equal yields 0; go DONE.
REQ-020 DONE: RESP_VALID=1; RESPONSE and SAT held stable until RESP_VALID&&RESP_READY, then IDLE next cycle.
REQ-021 RESP_READY already high on DONE entry SHALL complete in that first DONE cycle.
REQ-022 Latency: first RESP_VALID cycle SHALL be NUM_RO*(WINDOW+SETTLE_CYC+2)+1 cycles after the accept edge.
REQ-023 BUSY SHALL be 1 in every state except IDLE.
REQ-024 Timer and idx SHALL not wrap: timer width ceil(log2(WINDOW)), compared for equality only.
REQ-025 RESPONSE SHALL retain last completed value in IDLE; RESP_VALID=0 outside DONE.

Reset
REQ-026 RESET sampled high at a CLK edge SHALL force IDLE from any state, including mid-RUN.
REQ-027 Reset values: REQ_READY=1 (IDLE), RO_EN=0, CNT_CLEAR=0, RO_SEL=0, RO_CHALLENGE=0, RESP_VALID=0, RESPONSE=0, SAT=0, BUSY=0, idx=0, timer=0.
REQ-028 count[] array need not be reset; it SHALL be fully rewritten before any COMPARE.

Structure
REQ-029 Package ro_puf_pkg SHALL hold NUM_RO default, COUNT_W default, and the state enum typedef.
REQ-030 Window timer SHALL be sub-module ro_window_timer (load, run, done pulse at WINDOW-1); all else inline.

Verification (WINDOW=16, SETTLE_CYC=2, NUM_RO=9, RESP_READY=1)
REQ-031 Counts model returns 100+10*idx -> RESPONSE=8'h00, SAT=0, RESP_VALID exactly 181 cycles after accept.
REQ-032 Counts 200-10*idx -> RESPONSE=8'hFF; counts all 50 -> RESPONSE=8'h00.
REQ-033 idx 4 returns 32'hFFFFFFFF, others 10 -> SAT=1, RESPONSE=8'h10 (bit4 set, bit3 clear).
REQ-034 RESP_READY low 5 cycles in DONE -> RESP_VALID, RESPONSE stable 5 cycles; REQ_VALID pulsed while BUSY ignored.
REQ-035 RESET at cycle 8 of RUN for idx 3 -> next cycle RO_EN=0, BUSY=0, REQ_READY=1; new request completes normally.
REQ-036 Assertions: RO_EN high exactly 16 consecutive cycles per RO, one CNT_CLEAR pulse per RO, RO_SEL steps 0..8.
